// File: rtl/miriscv_lsu_pkg.sv
// Shared size codes, FSM encoding and the misalignment rule for the load-store unit.
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Undefined size codes are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: return 1'b0;
      LDST_H, LDST_HU: return off[0];
      default:         return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-memory request/grant/rvalid bus between the LSU (master) and memory (slave).
interface miriscv_lsu_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: store byte enables/replication and load extraction/extension.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfword lanes look only at off[1], so a stray off[0] is simply ignored.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      LDST_B, LDST_BU: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_size_i)
      LDST_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LDST_BU: ld_data_o = {24'd0, ld_byte};
      LDST_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      LDST_HU: ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load-store unit: one req/gnt/rvalid transaction per access, stalling the core until done.
// Optional MIRISCV_LSU_MISALIGN_EN traps misaligned H/W accesses without touching the bus.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misaligned_o,
  miriscv_lsu_if.master bus
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] ldata_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        req_misaligned;
  logic        accept;
  logic        load_done;

`ifdef MIRISCV_LSU_MISALIGN_EN
  logic mis_q;
  assign req_misaligned = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && lsu_req_i;
  assign load_done = (state_q == ST_WAIT) && bus.data_rvalid && !we_q;

  miriscv_lsu_align u_align (
    .st_size_i  (lsu_size_i),
    .st_off_i   (lsu_addr_i[1:0]),
    .st_data_i  (lsu_data_i),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_size_i  (size_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (bus.data_rdata),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Once out of IDLE the transaction runs to completion regardless of lsu_req_i.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (lsu_req_i) state_d = req_misaligned ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus.data_gnt) state_d = ST_WAIT;
      ST_WAIT: if (bus.data_rvalid) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.data_req    = (state_q == ST_REQ);
    lsu_stall_req_o = lsu_req_i && (state_q != ST_DONE);
`ifdef MIRISCV_LSU_MISALIGN_EN
    lsu_misaligned_o = (state_q == ST_DONE) && mis_q;
`else
    lsu_misaligned_o = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      ldata_q <= 32'd0;
`ifdef MIRISCV_LSU_MISALIGN_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        off_q   <= lsu_addr_i[1:0];
        addr_q  <= {lsu_addr_i[31:2], 2'b00};
        be_q    <= st_be;
        wdata_q <= st_wdata;
`ifdef MIRISCV_LSU_MISALIGN_EN
        mis_q   <= req_misaligned;
`endif
      end
      if (load_done) ldata_q <= ld_data;
    end
  end

  assign bus.data_we    = we_q;
  assign bus.data_be    = be_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign lsu_data_o     = ldata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Self-checking bench for miriscv_lsu: directed table, reset-in-WAIT sequence, random ops vs model.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = 3'd0;
  logic [31:0] lsu_addr = 32'd0;
  logic [31:0] lsu_data = 32'd0;
  logic        stall;
  logic [31:0] ldata;
  logic        mis;

  always #5 clk = ~clk;

  miriscv_lsu_if bus();

  miriscv_lsu dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lsu_req_i        (lsu_req),
    .lsu_we_i         (lsu_we),
    .lsu_size_i       (lsu_size),
    .lsu_addr_i       (lsu_addr),
    .lsu_data_i       (lsu_data),
    .lsu_stall_req_o  (stall),
    .lsu_data_o       (ldata),
    .lsu_misaligned_o (mis),
    .bus              (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gl;   // extra REQ cycles before grant
    int          rl;   // extra WAIT cycles before rvalid
  } op_t;

  typedef struct {
    int          stall_n;
    int          req_n;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        mis;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference behaviour from lane arithmetic: width in bytes, offset, shift and mask.
  function automatic res_t model(input op_t op, input logic [31:0] prev);
    res_t        e;
    int          nb;
    int          off;
    bit          sgn;
    logic [31:0] v;
    logic [31:0] mask;
    e = '{default: 0};
    case (op.size)
      3'd0:    begin nb = 1; sgn = 1'b1; end
      3'd4:    begin nb = 1; sgn = 1'b0; end
      3'd1:    begin nb = 2; sgn = 1'b1; end
      3'd5:    begin nb = 2; sgn = 1'b0; end
      default: begin nb = 4; sgn = 1'b0; end
    endcase
    off = int'(op.addr[1:0]);
`ifdef MIRISCV_LSU_MISALIGN_EN
    e.mis = (off % nb) != 0;
`endif
    if (nb == 2) off = off - (off % 2);
    if (nb == 4) off = 0;
    e.we    = op.we;
    e.addr  = op.addr - 32'(op.addr[1:0]);
    e.be    = 4'(((1 << nb) - 1) << off);
    e.wdata = (nb == 1) ? 32'(op.wdata[7:0]) * 32'h01010101 :
              (nb == 2) ? 32'(op.wdata[15:0]) * 32'h00010001 : op.wdata;
    mask    = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v       = (op.rdata >> (8 * off)) & mask;
    if (sgn && v[8 * nb - 1]) v = v | ~mask;
    e.ldata   = (op.we || e.mis) ? prev : v;
    e.stall_n = e.mis ? 1 : 3 + op.gl + op.rl;
    e.req_n   = e.mis ? 0 : op.gl + 1;
    return e;
  endfunction

  // Called at a falling edge; plays the core and the memory until the stall drops (DONE).
  task automatic do_op(input op_t op, output res_t r);
    bit granted;
    bit done;
    int wcnt;
    r = '{default: 0};
    lsu_req  = 1'b1;
    lsu_we   = op.we;
    lsu_size = op.size;
    lsu_addr = op.addr;
    lsu_data = op.wdata;
    bus.data_rdata = op.rdata;
    granted = 1'b0;
    done    = 1'b0;
    wcnt    = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (!stall) begin
        done    = 1'b1;
        r.mis   = mis;
        r.ldata = ldata;
        r.we    = bus.data_we;
        r.be    = bus.data_be;
        r.addr  = bus.data_addr;
        r.wdata = bus.data_wdata;
      end else begin
        r.stall_n++;
        if (bus.data_req) begin
          r.req_n++;
          bus.data_gnt    = (r.req_n > op.gl);
          bus.data_rvalid = 1'b0;
          if (bus.data_gnt) granted = 1'b1;
        end else if (granted) begin
          // gnt is left high in WAIT so a second request would be counted.
          wcnt++;
          bus.data_rvalid = (wcnt > op.rl);
        end else begin
          bus.data_gnt    = 1'b0;
          bus.data_rvalid = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!done) chk("op timeout", 32'd0, 32'd1);
    lsu_req         = 1'b0;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t a, input res_t e);
    chk({tag, " stall"}, 32'(a.stall_n), 32'(e.stall_n));
    chk({tag, " req"},   32'(a.req_n),   32'(e.req_n));
    chk({tag, " ldata"}, a.ldata,        e.ldata);
    chk({tag, " mis"},   32'(a.mis),     32'(e.mis));
    if (!e.mis) begin
      chk({tag, " we"},    32'(a.we), 32'(e.we));
      chk({tag, " be"},    32'(a.be), 32'(e.be));
      chk({tag, " addr"},  a.addr,    e.addr);
      chk({tag, " wdata"}, a.wdata,   e.wdata);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, 32'(stall),          32'd0);
    chk({tag, " req"},   32'(bus.data_req),   32'd0);
    chk({tag, " we"},    32'(bus.data_we),    32'd0);
    chk({tag, " be"},    32'(bus.data_be),    32'd0);
    chk({tag, " addr"},  bus.data_addr,       32'd0);
    chk({tag, " wdata"}, bus.data_wdata,      32'd0);
    chk({tag, " ldata"}, ldata,               32'd0);
    chk({tag, " mis"},   32'(mis),            32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    res_t        r;
    res_t        e;
    op_t         op;
    logic [31:0] prev;

    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'd0;

    //            we    size     addr          wdata         rdata          gl rl    stall req we    be       addr          wdata         ldata         mis
    tbl[0] = '{'{1'b0, LDST_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0}, '{3, 1, 1'b0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0}};
    tbl[1] = '{'{1'b0, LDST_B,  32'h103, 32'h0,        32'h80112233, 0, 0}, '{3, 1, 1'b0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 1'b0}};
    tbl[2] = '{'{1'b0, LDST_BU, 32'h103, 32'h0,        32'h80112233, 0, 0}, '{3, 1, 1'b0, 4'b1000, 32'h100, 32'h0,        32'h00000080, 1'b0}};
    tbl[3] = '{'{1'b0, LDST_HU, 32'h102, 32'h0,        32'h80112233, 0, 0}, '{3, 1, 1'b0, 4'b1100, 32'h100, 32'h0,        32'h00008011, 1'b0}};
    tbl[4] = '{'{1'b1, LDST_B,  32'h101, 32'h12345678, 32'h0,        0, 0}, '{3, 1, 1'b1, 4'b0010, 32'h100, 32'h78787878, 32'h00008011, 1'b0}};
    tbl[5] = '{'{1'b0, LDST_W,  32'h200, 32'h0,        32'h0BADF00D, 3, 1}, '{7, 4, 1'b0, 4'b1111, 32'h200, 32'h0,        32'h0BADF00D, 1'b0}};
    tbl[6] = '{'{1'b0, LDST_H,  32'h100, 32'h0,        32'h00008001, 0, 0}, '{3, 1, 1'b0, 4'b0011, 32'h100, 32'h0,        32'hFFFF8001, 1'b0}};
    tbl[7] = '{'{1'b1, LDST_H,  32'h102, 32'hAAAA5555, 32'h0,        0, 0}, '{3, 1, 1'b1, 4'b1100, 32'h100, 32'h55555555, 32'hFFFF8001, 1'b0}};
    tbl[8] = '{'{1'b1, LDST_B,  32'h3F3, 32'h000000AB, 32'h0,        1, 2}, '{6, 2, 1'b1, 4'b1000, 32'h3F0, 32'hABABABAB, 32'hFFFF8001, 1'b0}};
`ifdef MIRISCV_LSU_MISALIGN_EN
    tbl[9] = '{'{1'b0, LDST_W,  32'h102, 32'h0,        32'h13579BDF, 0, 0}, '{1, 0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'hFFFF8001, 1'b1}};
`else
    tbl[9] = '{'{1'b0, LDST_W,  32'h102, 32'h0,        32'h13579BDF, 0, 0}, '{3, 1, 1'b0, 4'b1111, 32'h100, 32'h0,        32'h13579BDF, 1'b0}};
`endif

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, r);
      compare($sformatf("vec%0d", i), r, tbl[i].exp);
      @(negedge clk);
    end

    // Reset while waiting for rvalid: everything clears and a late rvalid is dropped.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = LDST_W; lsu_addr = 32'h300; lsu_data = 32'd0;
    @(negedge clk);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    bus.data_gnt = 1'b0;
    #1;
    chk("pre-reset stall", 32'(stall), 32'd1);
    chk("pre-reset req",   32'(bus.data_req), 32'd0);
    rst = 1'b1;
    lsu_req = 1'b0;
    #1;
    chk_all_zero("mid-reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.data_rvalid = 1'b0;
    #1;
    chk("late rvalid ldata", ldata, 32'd0);
    chk("late rvalid req",   32'(bus.data_req), 32'd0);
    @(negedge clk);
    prev = 32'd0;
    op = '{1'b0, LDST_W, 32'h300, 32'h0, 32'hCAFEF00D, 0, 0};
    e  = model(op, prev);
    do_op(op, r);
    compare("post-reset LW", r, e);
    chk("post-reset LW value", r.ldata, 32'hCAFEF00D);
    prev = e.ldata;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      op.we    = 1'($urandom_range(0, 1));
      op.size  = 3'($urandom_range(0, 7));
      op.addr  = $urandom;
      op.wdata = $urandom;
      op.rdata = $urandom;
      op.gl    = $urandom_range(0, 3);
      op.rl    = $urandom_range(0, 3);
      e = model(op, prev);
      do_op(op, r);
      compare($sformatf("rnd%0d", i), r, e);
      prev = e.ldata;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
